// File: rtl/seq_sub_n_pkg.sv
// Shared ALU package: FSM state encoding and default widths
// for the chunked subtract/compare path.
package seq_sub_n_pkg;

  localparam int N_DEF = 16;
  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/rca_n.sv
// Generic n-bit ripple-carry adder: s = x + y + c_in.
// Carry-out on c_out.
module rca_n #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         c_in,
  output logic [n-1:0] s,
  output logic         c_out
);

  logic [n:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < n; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign c_out = c[n];

endmodule

// File: rtl/seq_sub_n.sv
// Multi-cycle chunked subtractor: d = a + ~b + 1, W bits per
// cycle, LS chunk first, carry held in a register between chunks.
module seq_sub_n
  import seq_sub_n_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         borrow_out,
  output logic         ovf
);

  localparam int CHUNKS = N / W;
  localparam int CW     = cnt_w(CHUNKS);
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  state_t state, state_nx;

  logic [N-1:0]  a_q, b_q, d_q;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          borrow_q, ovf_q;

  logic [W-1:0]  a_ck, b_ck, sum;
  logic          c_nx;
  logic          last;
  logic          accept;

  assign a_ck   = a_q[int'(cnt)*W +: W];
  assign b_ck   = b_q[int'(cnt)*W +: W];
  assign last   = (cnt == LAST);
  assign accept = in_valid && in_ready;

  rca_n #(.n(W)) u_rca (
    .x     (a_ck),
    .y     (~b_ck),
    .c_in  (carry),
    .s     (sum),
    .c_out (c_nx)
  );

  // Flags decode straight from state so reset kills them at once
  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == DONE);
  assign d          = d_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept)    state_nx = RUN;
      RUN:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      cnt      <= '0;
      carry    <= 1'b1;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      cnt   <= '0;
      carry <= 1'b1;
    end else if (state == RUN) begin
      d_q[int'(cnt)*W +: W] <= sum;
      carry <= c_nx;
      cnt   <= last ? '0 : cnt + 1'b1;
      if (last) begin
        borrow_q <= ~c_nx;
        // sum[W-1] is the new result MSB on the final chunk
        ovf_q    <= (a_q[N-1] != b_q[N-1]) &&
                    (sum[W-1] != a_q[N-1]);
      end
    end
  end

endmodule

// File: tb/tb_seq_sub_n.sv
// Bench for seq_sub_n (N=16, W=4): vector table, scoreboard
// queue, and hand sequences for stall, abort and back-to-back.
module tb_seq_sub_n;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] d;
  logic        borrow_out;
  logic        ovf;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    res_t        r;
  } vec_t;

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;

  seq_sub_n #(.N(16), .W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d          (d),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] x,
                                 input logic [15:0] y);
    res_t r;
    r.d  = x - y;
    r.bo = (x < y);
    r.ov = (x[15] != y[15]) && (r.d[15] != x[15]);
    return r;
  endfunction

  task automatic pop_chk(input string nm, output res_t e);
    e = '0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s got=result exp=empty_queue", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".d"}, 32'(d), 32'(e.d));
      chk({nm, ".borrow"}, 32'(borrow_out), 32'(e.bo));
      chk({nm, ".ovf"}, 32'(ovf), 32'(e.ov));
    end
  endtask

  task automatic wait_valid(input string nm, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    if (!out_valid) chk({nm, ".timeout"}, 32'(out_valid), 32'd1);
  endtask

  // Called at a negedge; returns at a negedge with the block idle
  task automatic run_op(input string nm, input logic [15:0] x,
                        input logic [15:0] y, input res_t e);
    int   lat;
    res_t got;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = x;
    b = y;
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    wait_valid(nm, lat);
    chk({nm, ".latency"}, 32'(lat), 32'd4);
    pop_chk(nm, got);
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".drop"}, 32'(out_valid), 32'd0);
    chk({nm, ".rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t tbl[6];
    res_t e;
    int   lat;
    int   nacc, nres, done0, acc1;
    logic never;
    logic [15:0] ra, rb;

    tbl[0] = '{16'h1234, 16'h0234, '{16'h1000, 1'b0, 1'b0}};
    tbl[1] = '{16'h0000, 16'h0001, '{16'hFFFF, 1'b1, 1'b0}};
    tbl[2] = '{16'h8000, 16'h0001, '{16'h7FFF, 1'b0, 1'b1}};
    tbl[3] = '{16'hFFFF, 16'h0000, '{16'hFFFF, 1'b0, 1'b0}};
    tbl[4] = '{16'h5555, 16'hAAAA, '{16'hAAAB, 1'b1, 1'b1}};
    tbl[5] = '{16'h8000, 16'h8000, '{16'h0000, 1'b0, 1'b0}};

    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.d", 32'(d), 32'd0);
    chk("rst.borrow", 32'(borrow_out), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].r);

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op($sformatf("rnd%0d", i), ra, rb, model(ra, rb));
    end

    // output stall with a stray request
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'h7FFF;
    b = 16'hFFFF;
    sb.push_back('{16'h8000, 1'b1, 1'b1});
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid("stall", lat);
    chk("stall.latency", 32'(lat), 32'd4);
    pop_chk("stall", e);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 16'h0001;
      b = 16'h0002;
      chk($sformatf("stall%0d.valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d.rdy", i), 32'(in_ready), 32'd0);
      chk($sformatf("stall%0d.d", i), 32'(d), 32'(e.d));
      chk($sformatf("stall%0d.bo", i), 32'(borrow_out), 32'(e.bo));
      chk($sformatf("stall%0d.ovf", i), 32'(ovf), 32'(e.ov));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stall.end_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("stall.drop", 32'(out_valid), 32'd0);
    chk("stall.rdy", 32'(in_ready), 32'd1);

    // reset during the second RUN cycle
    in_valid = 1'b1;
    a = 16'h1234;
    b = 16'h0001;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort.valid", 32'(out_valid), 32'd0);
    chk("abort.rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.rel_rdy", 32'(in_ready), 32'd1);
    never = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) never = 1'b0;
    end
    chk("abort.no_valid", 32'(never), 32'd1);
    run_op("post", 16'h00FF, 16'h00FF, '{16'h0000, 1'b0, 1'b0});

    // back-to-back with in_valid held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    nacc  = 0;
    nres  = 0;
    done0 = -1;
    acc1  = -1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        pop_chk($sformatf("b2b%0d", nres), e);
        if (nres == 0) done0 = i;
        nres++;
      end
      if (in_valid && in_ready) begin
        if (nacc == 0) sb.push_back('{16'h0000, 1'b0, 1'b0});
        else           sb.push_back('{16'hFFFF, 1'b1, 1'b0});
        if (nacc == 1) acc1 = i;
        nacc++;
      end
      @(posedge clk);
      #1;
      if (nacc == 1) begin
        a = 16'h0001;
        b = 16'h0002;
      end else if (nacc >= 2) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b.accepts", 32'(nacc), 32'd2);
    chk("b2b.results", 32'(nres), 32'd2);
    chk("b2b.gap", 32'(acc1), 32'(done0 + 1));
    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_sub_n.md
Name: seq_sub_n

Overview:
- Multi-cycle chunked subtractor. Computes d = a - b as a + ~b + 1, processing W bits per cycle, least-significant chunk first, with a registered carry between chunks.
- Serves as the subtract/compare path of the ALU where area matters more than latency.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- N, 16, operand/result width; N must be a multiple of W.
- W, 4, chunk width processed per RUN cycle; 1 <= W <= N.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands a, b valid.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend, unsigned or two's-complement.
- b  input  N  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- d  output  N  difference a - b, mod 2^N.
- borrow_out  output  1  1 when unsigned a < b, i.e. the inverted final carry.
- ovf  output  1  signed overflow.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - out_valid=0, d=0, borrow_out=0, ovf=0, chunk counter=0, carry register=1.
  - in_ready=0 while rst is high, and 1 in the first cycle after release.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On the edge with in_valid&&in_ready: latch a and b into internal registers, set cnt=0, carry=1, go to RUN.
- RUN (in_ready=0):
  - Each edge computes chunk k=cnt: {c, d[kW+W-1:kW]} = a_k + ~b_k + carry; carry<=c; cnt<=cnt+1.
  - On the edge with cnt==N/W-1: go to DONE, set borrow_out=~c and ovf=(a[N-1]!=b[N-1])&&(d_new[N-1]!=a[N-1]).
- DONE:
  - out_valid=1; d, borrow_out and ovf are held stable; in_ready=0.
  - On the edge with out_ready=1: out_valid<=0 and go to IDLE.
  - d keeps its last value until the next computation starts.
- Latency:
  - Take the accept edge as edge 0. out_valid rises after edge N/W.
  - Minimum throughput is one operation per N/W+2 cycles.
- d may change during RUN; consumers use it only while out_valid=1.
- in_valid is ignored outside IDLE; a and b need not be held after acceptance.
- out_ready is ignored when out_valid=0.
- Reset asserted in RUN or DONE aborts the operation immediately: out_valid drops asynchronously and no partial result is ever flagged valid.
- W==N degenerates to a single RUN cycle; this configuration must be legal.
- cnt width is clog2(N/W), minimum 1 bit; it must not wrap before the DONE transition.

Decomposition:
- Shared package, ALU-wide: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default widths N_DEF=16, W_DEF=4.
- One natural sub-module: the W-bit chunk datapath. Reuse the team's ripple-carry adder rca_n with n=W, x=a chunk, y=~b chunk, c_in=carry register.
- FSM, counter, operand registers and flag logic stay in seq_sub_n.

Test Plan (N=16, W=4):
- a=0x1234, b=0x0234, out_ready=1 -> out_valid exactly 4 edges after accept; d=0x1000, borrow_out=0, ovf=0.
- a=0x0000, b=0x0001 -> d=0xFFFF, borrow_out=1, ovf=0.
- a=0x8000, b=0x0001 -> d=0x7FFF, borrow_out=0, ovf=1.
- a=0x7FFF, b=0xFFFF with out_ready=0 for 5 cycles:
  - d=0x8000, ovf=1, borrow_out=1, held stable throughout.
  - in_ready=0; a new in_valid during the stall is ignored.
  - Raising out_ready -> out_valid=0 next cycle, in_ready=1.
- Reset pulse on the 2nd RUN cycle of 0x1234-0x0001:
  - out_valid stays 0; in_ready=1 after release.
  - Next operation a=0x00FF, b=0x00FF -> d=0x0000, borrow_out=0, ovf=0.
- Back-to-back: issue 0xFFFF-0xFFFF, then 0x0001-0x0002 with in_valid held high continuously -> second op accepted in the first IDLE cycle after DONE; results 0x0000 then 0xFFFF with borrow_out 0 then 1.
